// File: rtl/awb_pkg.sv
// Shared encodings for the auto-white-balance gain controller.
package awb_pkg;

  // Operating modes as written through mode_in; code 3 behaves as bypass.
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_MANUAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;

  // Bayer pattern at pixel (0,0).
  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

  // Colour phase after XOR with the pixel parity: 0 = R, 1/2 = G, 3 = B.
  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_B = 2'd3;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIV_R  = 2'd1,
    ST_DIV_B  = 2'd2,
    ST_UPDATE = 2'd3
  } awb_state_t;

  // Unity gain in unsigned Q1.(gw-1).
  function automatic logic [31:0] unity(input int gw);
    return 32'd1 << (gw - 1);
  endfunction

endpackage

// File: rtl/awb_div.sv
// Restoring unsigned divider producing a QW-bit quotient.
// The caller guarantees num_i / den_i < 2**QW, so the upper DENW bits of
// the numerator are already smaller than the divisor and only QW
// subtract-and-shift steps are needed after the load cycle.
module awb_div #(
  parameter int DENW = 30,
  parameter int QW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DENW+QW-1:0]   num_i,
  input  logic [DENW-1:0]      den_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [QW-1:0]        quo_o
);

  localparam int CW = $clog2(QW + 1);

  logic [DENW-1:0] rem_q;
  logic [DENW-1:0] den_q;
  // Low numerator bits leave at the top while quotient bits enter at the bottom.
  logic [QW-1:0]   sh_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;

  logic [DENW:0]   trial;
  logic [DENW-1:0] diff;
  logic            take;

  assign trial = {rem_q, sh_q[QW-1]};
  assign take  = (trial >= {1'b0, den_q});
  // When take is set the true difference is below den_q, so DENW bits suffice.
  assign diff  = trial[DENW-1:0] - den_q;

  // Load on start, then one quotient bit per cycle down to terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && (cnt_q == '0)) begin
        rem_q <= num_i[DENW+QW-1:QW];
        sh_q  <= num_i[QW-1:0];
        den_q <= den_i;
        cnt_q <= CW'(QW);
      end else if (cnt_q != '0) begin
        rem_q  <= take ? diff : trial[DENW-1:0];
        sh_q   <= {sh_q[QW-2:0], take};
        cnt_q  <= cnt_q - 1'b1;
        done_q <= (cnt_q == CW'(1));
      end
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;
  assign quo_o  = sh_q;

endmodule

// File: rtl/awb_gain_ctrl.sv
// Auto-white-balance gain controller on the raw Bayer stream.
// Gains switch only at frame start; auto mode derives gray-world gains
// from the previous frame's colour sums and smooths them with an IIR.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | idle; waits for end of an auto frame to take the snapshot
// ST_DIV_R  | red gain: saturation precheck or divide
// ST_DIV_B  | blue gain: saturation precheck or divide
// ST_UPDATE | apply new auto gains unless auto mode was left meanwhile
module awb_gain_ctrl
  import awb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int GW        = 8,
  parameter int HW        = 11,
  parameter int VW        = 11,
  parameter int SMOOTH_SH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic [DW-1:0] din,
  input  logic [1:0]    bayer_start,
  input  logic [HW-1:0] h_active,
  input  logic [VW-1:0] v_active,
  input  logic [GW-1:0] r_gain_in,
  input  logic [GW-1:0] g_gain_in,
  input  logic [GW-1:0] b_gain_in,
  input  logic [1:0]    mode_in,
  input  logic          cfg_we,
  output logic [GW-1:0] r_gain_out,
  output logic [GW-1:0] g_gain_out,
  output logic [GW-1:0] b_gain_out,
  output logic          gain_valid,
  output logic          gain_upd,
  output logic          frame_done
);

  localparam int AW = DW + HW + VW;
  localparam logic [GW-1:0] UNITY = GW'(unity(GW));
  localparam logic [GW-1:0] GMAX  = '1;

  // Configuration shadow registers
  logic [1:0]    sh_mode_q, sh_mode_d;
  logic [GW-1:0] sh_r_q, sh_g_q, sh_b_q;
  logic [GW-1:0] sh_r_d, sh_g_d, sh_b_d;

  // Pixel-domain counters and sums
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [1:0]    bayer_q;
  logic [AW-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic [AW-1:0] sum_r_nx, sum_g_nx, sum_b_nx;
  logic [AW-1:0] add_r, add_g, add_b;

  // Control state
  awb_state_t    state_q;
  logic [1:0]    mode_q;
  logic [GW-1:0] r_q, g_q, b_q;
  logic          valid_q, upd_q, fd_q;
  logic [AW-1:0] snap_r_q, snap_g_q, snap_b_q;
  logic [GW-1:0] qr_q, qb_q;
  logic          div_started_q;
  logic          first_q;
  logic          disc_q;

  logic          h_last, v_last, frame_start, end_flag;
  logic [1:0]    mode_eff, bayer_eff, ph;
  logic          acc_en;
  logic [GW-1:0] fs_r, fs_g, fs_b;
  logic          fs_changed;

  logic [AW-1:0]    a_val;
  logic             sat_r, sat_b;
  logic             start_r, start_b, launch_b;
  logic             div_start, div_busy, div_done;
  logic [AW+GW-1:0] div_num;
  logic [AW-1:0]    div_den;
  logic [GW-1:0]    div_quo;

  logic signed [GW:0] dr, db, sr, sb;
  logic [GW:0]        r_sum, b_sum;
  logic [GW-1:0]      r_new, b_new;

  assign sh_mode_d = cfg_we ? mode_in   : sh_mode_q;
  assign sh_r_d    = cfg_we ? r_gain_in : sh_r_q;
  assign sh_g_d    = cfg_we ? g_gain_in : sh_g_q;
  assign sh_b_d    = cfg_we ? b_gain_in : sh_b_q;

  // Latch configuration writes; they wait here until the next frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode_q <= MODE_BYPASS;
      sh_r_q    <= UNITY;
      sh_g_q    <= UNITY;
      sh_b_q    <= UNITY;
    end else begin
      sh_mode_q <= sh_mode_d;
      sh_r_q    <= sh_r_d;
      sh_g_q    <= sh_g_d;
      sh_b_q    <= sh_b_d;
    end
  end

  assign h_last      = (h_cnt_q == h_active - HW'(1));
  assign v_last      = (v_cnt_q == v_active - VW'(1));
  assign frame_start = clken && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign end_flag    = clken && h_last && v_last;

  // The first pixel of a frame already belongs to the newly applied mode.
  assign mode_eff  = frame_start ? sh_mode_d   : mode_q;
  assign bayer_eff = frame_start ? bayer_start : bayer_q;
  assign ph        = bayer_eff ^ {v_cnt_q[0], h_cnt_q[0]};
  assign acc_en    = clken && (mode_eff == MODE_AUTO);

  assign add_r = (acc_en && (ph == PH_R)) ? AW'(din) : '0;
  assign add_b = (acc_en && (ph == PH_B)) ? AW'(din) : '0;
  assign add_g = (acc_en && (ph != PH_R) && (ph != PH_B)) ? AW'(din) : '0;

  assign sum_r_nx = sum_r_q + add_r;
  assign sum_g_nx = sum_g_q + add_g;
  assign sum_b_nx = sum_b_q + add_b;

  // Raster counters and per-colour sums, frozen while clken is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      bayer_q <= BAYER_RGGB;
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
    end else if (clken) begin
      if (frame_start) bayer_q <= bayer_start;
      if (h_last) begin
        h_cnt_q <= '0;
        v_cnt_q <= v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_q <= h_cnt_q + HW'(1);
      end
      if (end_flag) begin
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
      end else begin
        sum_r_q <= sum_r_nx;
        sum_g_q <= sum_g_nx;
        sum_b_q <= sum_b_nx;
      end
    end
  end

  assign fs_r = (sh_mode_d == MODE_MANUAL) ? sh_r_d : UNITY;
  assign fs_g = (sh_mode_d == MODE_MANUAL) ? sh_g_d : UNITY;
  assign fs_b = (sh_mode_d == MODE_MANUAL) ? sh_b_d : UNITY;
  assign fs_changed = (fs_r != r_q) || (fs_g != g_q) || (fs_b != b_q);

  // Gray-world target: half the green sum, since green has twice the sites.
  assign a_val = snap_g_q >> 1;
  // A quotient of 2*UNITY or more does not fit GW bits: saturate instead.
  assign sat_r = (snap_r_q == '0) || ({1'b0, a_val} >= {snap_r_q, 1'b0});
  assign sat_b = (snap_b_q == '0) || ({1'b0, a_val} >= {snap_b_q, 1'b0});

  assign start_r  = (state_q == ST_DIV_R) && !div_started_q && !sat_r && !div_busy;
  assign launch_b = (state_q == ST_DIV_R) && (div_started_q ? div_done : sat_r);
  // Blue starts in the same cycle the red result is taken, saving a cycle.
  assign start_b  = launch_b && !sat_b;

  assign div_start = start_r || start_b;
  assign div_den   = start_b ? snap_b_q : snap_r_q;
  assign div_num   = {1'b0, a_val, {(GW-1){1'b0}}};

  awb_div #(
    .DENW (AW),
    .QW   (GW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  assign dr    = $signed({1'b0, qr_q}) - $signed({1'b0, r_q});
  assign db    = $signed({1'b0, qb_q}) - $signed({1'b0, b_q});
  assign sr    = dr >>> SMOOTH_SH;
  assign sb    = db >>> SMOOTH_SH;
  assign r_sum = $unsigned($signed({1'b0, r_q}) + sr);
  assign b_sum = $unsigned($signed({1'b0, b_q}) + sb);
  assign r_new = first_q ? qr_q : (r_sum[GW] ? GMAX : r_sum[GW-1:0]);
  assign b_new = first_q ? qb_q : (b_sum[GW] ? GMAX : b_sum[GW-1:0]);

  // Mode switching at frame start, auto-gain FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ACCUM;
      mode_q        <= MODE_BYPASS;
      r_q           <= UNITY;
      g_q           <= UNITY;
      b_q           <= UNITY;
      valid_q       <= 1'b0;
      upd_q         <= 1'b0;
      fd_q          <= 1'b0;
      snap_r_q      <= '0;
      snap_g_q      <= '0;
      snap_b_q      <= '0;
      qr_q          <= '0;
      qb_q          <= '0;
      div_started_q <= 1'b0;
      first_q       <= 1'b0;
      disc_q        <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      fd_q  <= end_flag;

      if (frame_start) begin
        mode_q <= sh_mode_d;
        if (sh_mode_d != MODE_AUTO) begin
          r_q     <= fs_r;
          g_q     <= fs_g;
          b_q     <= fs_b;
          valid_q <= 1'b1;
          upd_q   <= fs_changed;
        end else if (mode_q != MODE_AUTO) begin
          first_q <= 1'b1;
        end
      end

      // Any non-auto cycle during a computation invalidates its result.
      if ((state_q != ST_ACCUM) && (mode_eff != MODE_AUTO)) disc_q <= 1'b1;

      case (state_q)
        ST_ACCUM: begin
          if (end_flag && (mode_q == MODE_AUTO)) begin
            snap_r_q      <= sum_r_nx;
            snap_g_q      <= sum_g_nx;
            snap_b_q      <= sum_b_nx;
            div_started_q <= 1'b0;
            disc_q        <= 1'b0;
            state_q       <= ST_DIV_R;
          end
        end
        ST_DIV_R: begin
          if (start_r) begin
            div_started_q <= 1'b1;
          end else if (launch_b) begin
            qr_q          <= div_started_q ? div_quo : GMAX;
            div_started_q <= start_b;
            state_q       <= ST_DIV_B;
          end
        end
        ST_DIV_B: begin
          if (!div_started_q) begin
            qb_q    <= GMAX;
            state_q <= ST_UPDATE;
          end else if (div_done) begin
            qb_q    <= div_quo;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          state_q <= ST_ACCUM;
          if (!disc_q && (mode_eff == MODE_AUTO)) begin
            r_q     <= r_new;
            g_q     <= UNITY;
            b_q     <= b_new;
            valid_q <= 1'b1;
            upd_q   <= 1'b1;
            first_q <= 1'b0;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign r_gain_out = r_q;
  assign g_gain_out = g_q;
  assign b_gain_out = b_q;
  assign gain_valid = valid_q;
  assign gain_upd   = upd_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl: one instance without smoothing and one
// with SMOOTH_SH=2 share all stimulus; 4x4 frames with hand-computed gains.
module tb_awb_gain_ctrl;
  import awb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clken, cfg_we;
  logic [7:0]  din;
  logic [1:0]  bayer_start, mode_in;
  logic [10:0] h_active, v_active;
  logic [7:0]  r_gain_in, g_gain_in, b_gain_in;

  logic [7:0]  r0, g0, b0, r2, g2, b2;
  logic        v0, u0, fd0, v2, u2, fd2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int upd0_n = 0, upd2_n = 0, fd0_n = 0;
  int fd_cyc = 0, upd_cyc = 0;
  logic [7:0] first_r, first_b;
  logic       first_v;
  int base;

  always #5 clk = ~clk;

  awb_gain_ctrl #(.SMOOTH_SH(0)) u_dut0 (
    .clk(clk), .rst(rst), .clken(clken), .din(din), .bayer_start(bayer_start),
    .h_active(h_active), .v_active(v_active),
    .r_gain_in(r_gain_in), .g_gain_in(g_gain_in), .b_gain_in(b_gain_in),
    .mode_in(mode_in), .cfg_we(cfg_we),
    .r_gain_out(r0), .g_gain_out(g0), .b_gain_out(b0),
    .gain_valid(v0), .gain_upd(u0), .frame_done(fd0)
  );

  awb_gain_ctrl #(.SMOOTH_SH(2)) u_dut2 (
    .clk(clk), .rst(rst), .clken(clken), .din(din), .bayer_start(bayer_start),
    .h_active(h_active), .v_active(v_active),
    .r_gain_in(r_gain_in), .g_gain_in(g_gain_in), .b_gain_in(b_gain_in),
    .mode_in(mode_in), .cfg_we(cfg_we),
    .r_gain_out(r2), .g_gain_out(g2), .b_gain_out(b2),
    .gain_valid(v2), .gain_upd(u2), .frame_done(fd2)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fd0) begin fd0_n = fd0_n + 1; fd_cyc = cyc; end
    if (u0)  begin upd0_n = upd0_n + 1; upd_cyc = cyc; end
    if (u2)  upd2_n = upd2_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] m, input logic [7:0] rg, gg, bg);
    mode_in = m; r_gain_in = rg; g_gain_in = gg; b_gain_in = bg;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // One 4x4 frame; colour of each site from the pattern, optional clken gaps.
  task automatic send_frame(input logic [7:0] rv, gv, bv, input logic [1:0] pat,
                            input int gap, input int cfg_at);
    logic [1:0] ph;
    bayer_start = pat;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        ph     = pat ^ {y[0], x[0]};
        din    = (ph == 2'd0) ? rv : (ph == 2'd3) ? bv : gv;
        clken  = 1'b1;
        cfg_we = ((y * 4 + x) == cfg_at);
        tick();
        cfg_we = 1'b0;
        if (y == 0 && x == 0) begin
          first_r = r0; first_b = b0; first_v = v0;
        end
        if (gap != 0 && x[0]) begin
          clken = 1'b0; din = 8'hEE;
          tick(); tick();
        end
      end
    end
    clken = 1'b0;
    din   = 8'h00;
    tick();
  endtask

  task automatic wait_upd(input string tag);
    int start;
    start = upd0_n;
    for (int i = 0; i < 64; i++) begin
      if (upd0_n != start) break;
      tick();
    end
    chk(tag, 32'(upd0_n != start), 32'd1);
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clken = 1'b0; cfg_we = 1'b0; din = 8'h00; bayer_start = 2'd0;
    h_active = 11'd4; v_active = 11'd4; mode_in = 2'd0;
    r_gain_in = 8'h00; g_gain_in = 8'h00; b_gain_in = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_r", r0, 8'h80);
    chk("rst_g", g0, 8'h80);
    chk("rst_b", b0, 8'h80);
    chk("rst_valid", v0, 1'b0);
    chk("rst_fd", fd0_n, 0);

    // 1: bypass frame
    send_frame(8'd10, 8'd20, 8'd30, 2'd0, 0, -1);
    chk("t1_valid_fs", first_v, 1'b1);
    chk("t1_r", r0, 8'h80);
    chk("t1_b", b0, 8'h80);
    chk("t1_no_upd", upd0_n, 0);
    chk("t1_fd_once", fd0_n, 1);

    // 2: manual gains written mid-frame
    mode_in = 2'd1; r_gain_in = 8'h90; g_gain_in = 8'h80; b_gain_in = 8'h70;
    send_frame(8'd10, 8'd20, 8'd30, 2'd0, 0, 5);
    chk("t2_hold_r", r0, 8'h80);
    chk("t2_hold_b", b0, 8'h80);
    chk("t2_hold_upd", upd0_n, 0);
    send_frame(8'd10, 8'd20, 8'd30, 2'd0, 0, -1);
    chk("t2_fs_r", first_r, 8'h90);
    chk("t2_fs_b", first_b, 8'h70);
    chk("t2_g", g0, 8'h80);
    chk("t2_upd_once", upd0_n, 1);

    // 3: auto, RGGB, R=32 G=64 B=128 -> r saturates, b=0x40
    write_cfg(2'd2, 8'h90, 8'h80, 8'h70);
    send_frame(8'd32, 8'd64, 8'd128, 2'd0, 0, -1);
    chk("t3_pre_r", r0, 8'h90);
    chk("t3_pre_valid", v0, 1'b1);
    wait_upd("t3_upd_seen");
    chk("t3_r", r0, 8'hFF);
    chk("t3_g", g0, 8'h80);
    chk("t3_b", b0, 8'h40);
    chk("t3_latency", 32'((upd_cyc - fd_cyc) <= 20), 32'd1);
    chk("t3_sh2_r", r2, 8'hFF);
    chk("t3_sh2_b", b2, 8'h40);

    // 4: BGGR with colours placed by pattern -> same gains; then sumR = 0
    send_frame(8'd32, 8'd64, 8'd128, 2'd3, 0, -1);
    wait_upd("t4_upd_seen");
    chk("t4_bggr_r", r0, 8'hFF);
    chk("t4_bggr_b", b0, 8'h40);
    send_frame(8'd0, 8'd64, 8'd64, 2'd0, 0, -1);
    wait_upd("t4z_upd_seen");
    chk("t4_zero_r", r0, 8'hFF);
    chk("t4_zero_b", b0, 8'h80);
    chk("t4_sh2_b", b2, 8'h50);

    // 5: re-enter auto through bypass; smoothing on the second result
    write_cfg(2'd0, 8'h00, 8'h00, 8'h00);
    send_frame(8'd1, 8'd1, 8'd1, 2'd0, 0, -1);
    chk("t5_byp_r", first_r, 8'h80);
    chk("t5_byp_r2", r2, 8'h80);
    write_cfg(2'd2, 8'h00, 8'h00, 8'h00);
    send_frame(8'd128, 8'd64, 8'd128, 2'd0, 0, -1);
    wait_upd("t5a_upd_seen");
    chk("t5a_r2", r2, 8'h40);
    chk("t5a_b2", b2, 8'h40);
    chk("t5a_r0", r0, 8'h40);
    send_frame(8'd64, 8'd64, 8'd128, 2'd0, 0, -1);
    wait_upd("t5b_upd_seen");
    chk("t5b_r2", r2, 8'h50);
    chk("t5b_b2", b2, 8'h40);
    chk("t5b_r0", r0, 8'h80);
    chk("t5b_latency", 32'((upd_cyc - fd_cyc) <= 20), 32'd1);

    // 6: reset while dividing blue
    send_frame(8'd128, 8'd64, 8'd128, 2'd0, 0, -1);
    for (int i = 0; i < 40; i++) begin
      if (u_dut0.state_q == ST_DIV_B) break;
      tick();
    end
    chk("t6_reach_divb", 32'(u_dut0.state_q == ST_DIV_B), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_r", r0, 8'h80);
    chk("t6_b", b0, 8'h80);
    chk("t6_valid", v0, 1'b0);
    chk("t6_state", 32'(u_dut0.state_q), 32'(ST_ACCUM));
    chk("t6_hcnt", 32'(u_dut0.h_cnt_q), 32'd0);
    chk("t6_vcnt", 32'(u_dut0.v_cnt_q), 32'd0);
    rst = 1'b0;
    base = upd0_n;
    repeat (30) tick();
    chk("t6_no_pulse", upd0_n - base, 0);

    // clken gaps mid-frame must not change the sums
    write_cfg(2'd2, 8'h00, 8'h00, 8'h00);
    send_frame(8'd64, 8'd64, 8'd128, 2'd0, 1, -1);
    wait_upd("t6g_upd_seen");
    chk("t6g_r0", r0, 8'h80);
    chk("t6g_b0", b0, 8'h40);
    chk("t6g_r2", r2, 8'h80);
    chk("t6g_b2", b2, 8'h40);
    chk("t6g_valid", v0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
